// File: rtl/axi_pkg.sv
// Single-beat AXI4 payload types shared by the synthetic CPU master and its peers.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_aw_t;

  typedef axi_aw_t axi_ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cpu_axi_master.sv
// Synthetic CPU: writes a word, reads it back and compares, NUM_ITER times over a
// per-CPU memory region, using one outstanding single-beat AXI4 transaction.
module cpu_axi_master
  import axi_pkg::*;
#(
  parameter int          NUM_ITER    = 16,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter logic [63:0] REGION_SIZE = 64'h1_0000,
  parameter logic [7:0]  AXI_ID      = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_index,
  output axi_aw_t     o_axi_m_aw,
  input  logic        i_axi_m_awready,
  output logic        o_axi_m_awvalid,
  output axi_w_t      o_axi_m_w,
  input  logic        i_axi_m_wready,
  output logic        o_axi_m_wvalid,
  input  axi_b_t      i_axi_m_b,
  output logic        o_axi_m_bready,
  input  logic        i_axi_m_bvalid,
  output axi_ar_t     o_axi_m_ar,
  input  logic        i_axi_m_arready,
  output logic        o_axi_m_arvalid,
  input  axi_r_t      i_axi_m_r,
  output logic        o_axi_m_rready,
  input  logic        i_axi_m_rvalid,
  output logic        o_done,
  output logic [31:0] o_err_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_WAIT_B = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_WAIT_R = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]  state_reg;
  logic [31:0] iter_reg;
  logic [31:0] err_cnt_reg;
  logic        awvalid_reg;
  logic        wvalid_reg;
  logic        arvalid_reg;

  logic [63:0] addr;
  logic [63:0] wdata;
  logic        last_iter;
  logic        aw_clear;
  logic        w_clear;
  logic        b_bad;
  logic        r_bad;

  // Payloads derive only from registered state, so they stay stable while a valid waits.
  assign addr      = BASE_ADDR + (64'(cpu_index) * REGION_SIZE) + (64'(iter_reg) << 3);
  assign wdata     = {cpu_index, iter_reg};
  assign last_iter = (iter_reg == 32'(NUM_ITER - 1));

  // A channel is finished once its valid is gone or is being accepted this cycle.
  assign aw_clear = !awvalid_reg || i_axi_m_awready;
  assign w_clear  = !wvalid_reg || i_axi_m_wready;

  assign b_bad = (i_axi_m_b.resp != RESP_OKAY) || (i_axi_m_b.id != AXI_ID);
  assign r_bad = (i_axi_m_r.data != wdata) || (i_axi_m_r.resp != RESP_OKAY) ||
                 !i_axi_m_r.last || (i_axi_m_r.id != AXI_ID);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      iter_reg    <= '0;
      err_cnt_reg <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_reg   <= S_WRITE;
          awvalid_reg <= 1'b1;
          wvalid_reg  <= 1'b1;
        end
        S_WRITE: begin
          if (awvalid_reg && i_axi_m_awready) awvalid_reg <= 1'b0;
          if (wvalid_reg && i_axi_m_wready) wvalid_reg <= 1'b0;
          if (aw_clear && w_clear) state_reg <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (i_axi_m_bvalid) begin
            if (b_bad) err_cnt_reg <= sat_inc(err_cnt_reg);
            state_reg   <= S_READ;
            arvalid_reg <= 1'b1;
          end
        end
        S_READ: begin
          if (i_axi_m_arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= S_WAIT_R;
          end
        end
        S_WAIT_R: begin
          if (i_axi_m_rvalid) begin
            if (r_bad) err_cnt_reg <= sat_inc(err_cnt_reg);
            if (last_iter) begin
              state_reg <= S_DONE;
            end else begin
              iter_reg    <= iter_reg + 32'd1;
              state_reg   <= S_WRITE;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
            end
          end
        end
        S_DONE: state_reg <= S_DONE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign o_axi_m_aw      = '{id: AXI_ID, addr: addr, len: 8'd0, size: 3'd3, burst: BURST_INCR};
  assign o_axi_m_ar      = '{id: AXI_ID, addr: addr, len: 8'd0, size: 3'd3, burst: BURST_INCR};
  assign o_axi_m_w       = '{data: wdata, strb: 8'hFF, last: 1'b1};
  assign o_axi_m_awvalid = awvalid_reg;
  assign o_axi_m_wvalid  = wvalid_reg;
  assign o_axi_m_arvalid = arvalid_reg;
  assign o_axi_m_bready  = (state_reg == S_WAIT_B);
  assign o_axi_m_rready  = (state_reg == S_WAIT_R);
  assign o_done          = (state_reg == S_DONE);
  assign o_err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Bench for cpu_axi_master: a memory-backed AXI slave with adjustable ready delays
// and fault injection, checked against address/data rules computed per iteration.
module tb_cpu_axi_master;
  import axi_pkg::*;

  localparam int          N      = 16;
  localparam logic [63:0] BASE   = 64'h8000_0000;
  localparam logic [63:0] REGION = 64'h1_0000;
  localparam logic [7:0]  ID     = 8'h00;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_index;
  axi_aw_t     aw;
  axi_w_t      w;
  axi_ar_t     ar;
  axi_b_t      b;
  axi_r_t      r;
  logic        awready, wready, arready;
  logic        awvalid, wvalid, arvalid;
  logic        bvalid, rvalid, bready, rready;
  logic        done;
  logic [31:0] err_cnt;

  int checks = 0;
  int failures = 0;

  // Slave configuration (written only by the stimulus block)
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit rand_mode = 1'b0;
  int bresp_err_iter = -1, rcorrupt_iter = -1;

  // Slave state (written only by the slave process)
  int aw_cnt, w_cnt, ar_cnt, aw_dly, w_dly, ar_dly;
  int wr_count, rd_count, aw_hold, stab_err, cyc = 0;
  logic aw_got, w_got, aw_stall, w_stall, ar_stall;
  logic [63:0] pend_addr, pend_data;
  axi_aw_t aw_prev;
  axi_w_t  w_prev;
  axi_ar_t ar_prev;
  logic [63:0] mem [logic [63:0]];
  axi_aw_t aw_log[$];
  axi_w_t  w_log[$];
  axi_ar_t ar_log[$];
  int aw_hold_log[$], aw_time_log[$], w_time_log[$];

  cpu_axi_master #(
    .NUM_ITER(N), .BASE_ADDR(BASE), .REGION_SIZE(REGION), .AXI_ID(ID)
  ) dut (
    .clk(clk), .rst(rst), .cpu_index(cpu_index),
    .o_axi_m_aw(aw), .i_axi_m_awready(awready), .o_axi_m_awvalid(awvalid),
    .o_axi_m_w(w), .i_axi_m_wready(wready), .o_axi_m_wvalid(wvalid),
    .i_axi_m_b(b), .o_axi_m_bready(bready), .i_axi_m_bvalid(bvalid),
    .o_axi_m_ar(ar), .i_axi_m_arready(arready), .o_axi_m_arvalid(arvalid),
    .i_axi_m_r(r), .o_axi_m_rready(rready), .i_axi_m_rvalid(rvalid),
    .o_done(done), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  assign awready = (aw_cnt >= aw_dly);
  assign wready  = (w_cnt >= w_dly);
  assign arready = (ar_cnt >= ar_dly);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_dly <= aw_delay; w_dly <= w_delay; ar_dly <= ar_delay;
      aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
      b <= '0; r <= '0;
      wr_count <= 0; rd_count <= 0; aw_hold <= 0; stab_err <= 0;
      aw_stall <= 1'b0; w_stall <= 1'b0; ar_stall <= 1'b0;
      aw_log.delete(); w_log.delete(); ar_log.delete();
      aw_hold_log.delete(); aw_time_log.delete(); w_time_log.delete();
    end else begin
      // A valid that waited last cycle must still be up with an unchanged payload.
      if (aw_stall && (!awvalid || aw !== aw_prev)) stab_err <= stab_err + 1;
      if (w_stall && (!wvalid || w !== w_prev)) stab_err <= stab_err + 1;
      if (ar_stall && (!arvalid || ar !== ar_prev)) stab_err <= stab_err + 1;
      aw_stall <= awvalid && !awready; aw_prev <= aw;
      w_stall  <= wvalid && !wready;   w_prev  <= w;
      ar_stall <= arvalid && !arready; ar_prev <= ar;

      if (awvalid) begin
        if (awready) begin
          aw_log.push_back(aw); aw_hold_log.push_back(aw_hold + 1); aw_time_log.push_back(cyc);
          aw_hold <= 0; aw_cnt <= 0; aw_got <= 1'b1; pend_addr <= aw.addr;
          aw_dly <= rand_mode ? int'($urandom_range(0, 3)) : aw_delay;
        end else begin
          aw_hold <= aw_hold + 1; aw_cnt <= aw_cnt + 1;
        end
      end
      if (wvalid) begin
        if (wready) begin
          w_log.push_back(w); w_time_log.push_back(cyc);
          w_cnt <= 0; w_got <= 1'b1; pend_data <= w.data;
          w_dly <= rand_mode ? int'($urandom_range(0, 3)) : w_delay;
        end else begin
          w_cnt <= w_cnt + 1;
        end
      end
      if (aw_got && w_got && !bvalid) begin
        mem[pend_addr] = pend_data;
        aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1;
        b <= '{id: ID, resp: (wr_count == bresp_err_iter) ? RESP_SLVERR : RESP_OKAY};
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; wr_count <= wr_count + 1;
      end
      if (arvalid) begin
        if (arready) begin
          ar_log.push_back(ar);
          ar_cnt <= 0; rvalid <= 1'b1;
          ar_dly <= rand_mode ? int'($urandom_range(0, 3)) : ar_delay;
          r <= '{id: ID,
                 data: (mem.exists(ar.addr) ? mem[ar.addr] : 64'h0) ^
                       ((rd_count == rcorrupt_iter) ? 64'h1 : 64'h0),
                 resp: RESP_OKAY, last: 1'b1};
        end else begin
          ar_cnt <= ar_cnt + 1;
        end
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0; rd_count <= rd_count + 1;
      end
    end
  end

  function automatic logic [63:0] model_addr(input logic [31:0] cpu, input int i);
    return BASE + 64'(cpu) * REGION + 64'(i) * 64'd8;
  endfunction

  function automatic logic [63:0] model_data(input logic [31:0] cpu, input int i);
    return {cpu, 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    $display("run %s: cycles=%0d err_cnt=%0d", tag, n, err_cnt);
  endtask

  task automatic check_traffic(input string tag, input logic [31:0] cpu);
    int bad_attr = 0;
    check({tag, "_aw_count"}, 64'(aw_log.size()), 64'(N));
    check({tag, "_ar_count"}, 64'(ar_log.size()), 64'(N));
    for (int i = 0; i < N && i < aw_log.size() && i < w_log.size() && i < ar_log.size(); i++) begin
      check($sformatf("%s_aw_addr%0d", tag, i), aw_log[i].addr, model_addr(cpu, i));
      check($sformatf("%s_wdata%0d", tag, i), w_log[i].data, model_data(cpu, i));
      check($sformatf("%s_ar_addr%0d", tag, i), ar_log[i].addr, model_addr(cpu, i));
      if (aw_log[i].id != ID || aw_log[i].len != 8'd0 || aw_log[i].size != 3'd3 ||
          aw_log[i].burst != BURST_INCR || ar_log[i].len != 8'd0 || ar_log[i].size != 3'd3 ||
          ar_log[i].burst != BURST_INCR || ar_log[i].id != ID ||
          w_log[i].strb != 8'hFF || !w_log[i].last)
        bad_attr++;
    end
    check({tag, "_attr_errors"}, 64'(bad_attr), 64'd0);
    check({tag, "_stability"}, 64'(stab_err), 64'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awvalid"}, 64'(awvalid), 64'd0);
    check({tag, "_wvalid"}, 64'(wvalid), 64'd0);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd0);
    check({tag, "_bready"}, 64'(bready), 64'd0);
    check({tag, "_rready"}, 64'(rready), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err_cnt), 64'd0);
  endtask

  initial begin
    int n;
    int exp_err;
    logic [31:0] cpu;

    rst = 1'b1;
    cpu_index = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Always-ready slave, CPU 0
    run_to_done("A");
    check("A_aw0_addr", aw_log.size() > 0 ? aw_log[0].addr : 64'hX, 64'h8000_0000);
    check("A_w0_data", w_log.size() > 0 ? w_log[0].data : 64'hX, 64'h0);
    check("A_err", 64'(err_cnt), 64'd0);
    check_traffic("A", 32'd0);
    repeat (10) @(negedge clk);
    check("A_quiet_aw_count", 64'(aw_log.size()), 64'(N));
    check("A_quiet_awvalid", 64'(awvalid), 64'd0);
    check("A_quiet_arvalid", 64'(arvalid), 64'd0);
    check("A_still_done", 64'(done), 64'd1);

    // CPU 3: region offset plus iteration offset
    cpu_index = 32'd3;
    apply_reset();
    run_to_done("B");
    check("B_aw2_addr", aw_log.size() > 2 ? aw_log[2].addr : 64'hX, 64'h8003_0010);
    check("B_ar2_addr", ar_log.size() > 2 ? ar_log[2].addr : 64'hX, 64'h8003_0010);
    check("B_w2_data", w_log.size() > 2 ? w_log[2].data : 64'hX, 64'h0000_0003_0000_0002);
    check("B_err", 64'(err_cnt), 64'd0);
    check_traffic("B", 32'd3);

    // Slow AW (5 cycles) and W (1 cycle) ready
    cpu_index = 32'd1;
    aw_delay = 5; w_delay = 1;
    apply_reset();
    run_to_done("C");
    check("C_aw_hold0", aw_hold_log.size() > 0 ? 64'(aw_hold_log[0]) : 64'hX, 64'd6);
    check("C_w_first", (w_time_log.size() > 0 && aw_time_log.size() > 0) ?
          64'(w_time_log[0] < aw_time_log[0]) : 64'hX, 64'd1);
    check("C_err", 64'(err_cnt), 64'd0);
    check_traffic("C", 32'd1);
    aw_delay = 0; w_delay = 0;

    // SLVERR on the first write response
    cpu_index = 32'd2;
    bresp_err_iter = 0;
    apply_reset();
    run_to_done("D");
    check("D_err", 64'(err_cnt), 64'd1);
    check_traffic("D", 32'd2);
    bresp_err_iter = -1;

    // Corrupted read data on iteration 4
    cpu_index = 32'd5;
    rcorrupt_iter = 4;
    apply_reset();
    run_to_done("E");
    check("E_err", 64'(err_cnt), 64'd1);
    rcorrupt_iter = -1;

    // Randomized ready delays, CPU index and fault placement
    for (int k = 0; k < 3; k++) begin
      cpu = $urandom_range(0, 4095);
      cpu_index = cpu;
      rand_mode = 1'b1;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      bresp_err_iter = $urandom_range(0, 24);
      rcorrupt_iter = $urandom_range(0, 24);
      exp_err = ((bresp_err_iter < N) ? 1 : 0) + ((rcorrupt_iter < N) ? 1 : 0);
      apply_reset();
      run_to_done($sformatf("F%0d", k));
      check($sformatf("F%0d_err", k), 64'(err_cnt), 64'(exp_err));
      check_traffic($sformatf("F%0d", k), cpu);
    end
    rand_mode = 1'b0;
    aw_delay = 0; w_delay = 0; ar_delay = 0;
    bresp_err_iter = -1; rcorrupt_iter = -1;

    // Reset while waiting for read data aborts and restarts from iteration 0
    cpu_index = 32'd0;
    bresp_err_iter = 0;
    apply_reset();
    n = 0;
    while (!(rready && aw_log.size() >= 3) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("G_reached_wait_r", 64'(rready), 64'd1);
    check("G_err_before", 64'(err_cnt), 64'd1);
    rst = 1'b1;
    bresp_err_iter = -1;
    @(posedge clk);
    #1;
    check_idle_outputs("G_abort");
    @(negedge clk);
    rst = 1'b0;
    run_to_done("G");
    check("G_restart_addr", aw_log.size() > 0 ? aw_log[0].addr : 64'hX, 64'h8000_0000);
    check("G_err", 64'(err_cnt), 64'd0);
    check_traffic("G", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
